event_stream_reader: RTL and testbench
======================================

// Module: event_stream_reader
// PURPOSE
//  Read-side consumer of the formatter output FIFO. Drains SFIFO one byte at a time, frames the
//  stream into whole events using DRS_READDEPTH, and forwards bytes to the TCP transmit port with
//  backpressure. Event = 32 B header + 8x2 B flag + 8x2 B stopcell + 8x(4*DEPTH) B DRS4 data.
// PARAMETERS
//  SKID_DEPTH   4    output skid buffer entries (power of 2, >=2)
//  LEN_W        20   event byte-counter width (max 64+32*8191 = 262176)
// PORTS
//  CLK            in   1   single clock; all logic on posedge
//  RST_N          in   1   asynchronous, active-low reset
//  ENABLE         in   1   start new events while high
//  DRS_READDEPTH  in   13  cells per channel; sampled at event start only
//  SFIFO_RDCLK    out  1   = CLK
//  SFIFO_RDEN     out  1   FIFO read strobe (registered)
//  SFIFO_DOUT     in   8   FIFO data, valid when SFIFO_VALID
//  SFIFO_EMPTY    in   1   FIFO empty
//  SFIFO_VALID    in   1   read data valid, exactly 1 cycle after a RDEN
//  TCP_TX_FULL    in   1   sink full; no new write issued while sampled high
//  TCP_TX_WR      out  1   sink write strobe (registered)
//  TCP_TX_DATA    out  8   sink data (registered)
//  EVENT_DONE     out  1   1-cycle pulse after last byte of an event is written to sink
//  EVENT_COUNT    out  32  completed events, wraps 0xFFFFFFFF->0
//  BUSY           out  1   high from event start until EVENT_DONE
//  PROTO_ERR      out  1   sticky: VALID seen with no read outstanding; cleared by reset only
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, skid empty, counters 0.
//  Event length EVLEN = 64 + 32*DEPTH (LEN_W bits), computed from latched depth; DEPTH=0 -> 64.
//  States:
//   IDLE : if ENABLE & ~SFIFO_EMPTY -> latch depth, rd_cnt=0, wr_cnt=0, BUSY=1, go RUN.
//   RUN  : SFIFO_RDEN <= ~SFIFO_EMPTY & (skid_cnt + inflight < SKID_DEPTH) & (rd_cnt < EVLEN).
//          rd_cnt++ per RDEN. When rd_cnt reaches EVLEN -> DRAIN (no further RDEN this event).
//   DRAIN: wait inflight=0, skid empty, wr_cnt=EVLEN -> DONE.
//   DONE : EVENT_DONE=1 one cycle, EVENT_COUNT++, BUSY=0 -> IDLE (next event may start next cycle).
//  Read path: inflight set by RDEN, cleared by VALID; VALID pushes SFIFO_DOUT into skid.
//   VALID with inflight=0 -> byte dropped, PROTO_ERR set. Skid never overflows by construction.
//  Write path: TCP_TX_WR <= skid non-empty & ~TCP_TX_FULL; pop and TCP_TX_DATA <= head same edge.
//   wr_cnt++ per write. Push and pop in same cycle permitted (count unchanged).
//  ENABLE low mid-event: current event completes in full; no new event from IDLE.
//  SFIFO_EMPTY gaps: RDEN suppressed, state held, no byte lost or duplicated.
//  TCP_TX_FULL held: reads stop once skid+inflight = SKID_DEPTH; resume without loss.
//  Reset mid-event: immediate return to IDLE; partial event discarded; EVENT_COUNT cleared.
//  DRS_READDEPTH changes mid-event: ignored until next IDLE->RUN.
//  Throughput: 1 B/cycle sustained with FIFO non-empty and sink not full.
// STRUCTURE
//  Shared package: state enum (IDLE/RUN/DRAIN/DONE), HDR_BYTES=32, FLAG_BYTES=2, STOP_BYTES=2,
//   NUM_CH=8, event-length function of depth.
//  One sub-module: stream_skid_buf (SKID_DEPTH x 8 bit sync FIFO with count, push/pop/head).
// TESTING
//  1 DEPTH=1, FIFO preloaded 96 B (0..95), sink never full -> 96 writes, data 0..95 in order,
//    EVENT_DONE once, EVENT_COUNT=1, RDEN count=96.
//  2 DEPTH=1024, TCP_TX_FULL toggled 3 high/5 low -> 32832 bytes exact order, no write while
//    FULL sampled high, skid never >4.
//  3 DEPTH=4, two events (192 B each) back-to-back with random EMPTY gaps -> 2 EVENT_DONE pulses,
//    EVENT_COUNT=2, byte 192 is first byte of 2nd event.
//  4 ENABLE dropped after 10 B of DEPTH=2 event -> 128 B still forwarded, then idle despite data.
//  5 RST_N low after 50 B -> outputs 0 within reset, IDLE; after release new event starts cleanly.
//  6 Inject SFIFO_VALID with no RDEN -> PROTO_ERR=1, byte not forwarded, stays 1 until reset.

Source files
------------

// File: rtl/event_stream_reader_pkg.sv
// Shared state encoding and event geometry for the formatter-FIFO event reader.
// An event is a fixed header, per-channel flag and stop-cell words, then 4 bytes per cell per channel.
package event_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int HDR_BYTES  = 32;
  localparam int FLAG_BYTES = 2;
  localparam int STOP_BYTES = 2;
  localparam int NUM_CH     = 8;
  localparam int CELL_BYTES = 4;

  function automatic logic [31:0] ev_len(input logic [12:0] depth);
    return 32'(HDR_BYTES + NUM_CH * (FLAG_BYTES + STOP_BYTES))
         + 32'(NUM_CH * CELL_BYTES) * {19'd0, depth};
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small synchronous byte FIFO between the SFIFO read port and the TCP write port.
// Head is visible combinationally so a pop and its data leave on the same edge.
module stream_skid_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop & (count_q != '0);
  // A push into a full buffer is only legal when a pop frees a slot on the same edge.
  assign do_push = push & ((count_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/event_stream_reader.sv
// Drains the formatter FIFO byte by byte, frames whole events from the latched read depth,
// and forwards them to the TCP transmit port through a small skid buffer with backpressure.
module event_stream_reader
  import event_stream_reader_pkg::*;
#(
  parameter int SKID_DEPTH = 4,
  parameter int LEN_W      = 20
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic [12:0] DRS_READDEPTH,
  output logic        SFIFO_RDCLK,
  output logic        SFIFO_RDEN,
  input  logic [7:0]  SFIFO_DOUT,
  input  logic        SFIFO_EMPTY,
  input  logic        SFIFO_VALID,
  input  logic        TCP_TX_FULL,
  output logic        TCP_TX_WR,
  output logic [7:0]  TCP_TX_DATA,
  output logic        EVENT_DONE,
  output logic [31:0] EVENT_COUNT,
  output logic        BUSY,
  output logic        PROTO_ERR
);

  localparam int CW = $clog2(SKID_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] evlen_q, evlen_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             rden_q, rden_d;
  logic             inflight_q, inflight_d;
  logic             tx_wr_q, tx_wr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             event_done_q, event_done_d;
  logic [31:0]      event_count_q, event_count_d;
  logic             busy_q, busy_d;
  logic             proto_err_q, proto_err_d;

  logic [CW-1:0]    skid_cnt;
  logic [7:0]       skid_head;
  logic             rd_fire, skid_push, skid_pop, stray_valid;
  logic             room, more_to_read;
  logic [CW:0]      outstanding;

  // A strobe that meets EMPTY is not a read: the FIFO ignores it and returns no VALID.
  assign rd_fire     = rden_q & ~SFIFO_EMPTY;
  assign skid_push   = SFIFO_VALID & inflight_q;
  assign stray_valid = SFIFO_VALID & ~inflight_q;
  assign skid_pop    = (skid_cnt != '0) & ~TCP_TX_FULL;

  // The strobe already on the wire is counted too, so the skid can never be oversubscribed.
  assign outstanding  = {1'b0, skid_cnt} + (CW+1)'(inflight_q) + (CW+1)'(rden_q);
  assign room         = outstanding < (CW+1)'(SKID_DEPTH);
  assign more_to_read = ({1'b0, rd_cnt_q} + (LEN_W+1)'(rden_q)) < {1'b0, evlen_q};

  stream_skid_buf #(
    .DEPTH (SKID_DEPTH),
    .W     (8)
  ) u_skid (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (skid_push),
    .push_data (SFIFO_DOUT),
    .pop       (skid_pop),
    .head      (skid_head),
    .count     (skid_cnt)
  );

  always_comb begin
    state_d       = state_q;
    evlen_d       = evlen_q;
    rd_cnt_d      = rd_cnt_q + LEN_W'(rd_fire);
    wr_cnt_d      = wr_cnt_q + LEN_W'(skid_pop);
    rden_d        = 1'b0;
    inflight_d    = rd_fire | (inflight_q & ~SFIFO_VALID);
    tx_wr_d       = skid_pop;
    tx_data_d     = skid_pop ? skid_head : tx_data_q;
    event_done_d  = 1'b0;
    event_count_d = event_count_q;
    busy_d        = busy_q;
    proto_err_d   = proto_err_q | stray_valid;

    case (state_q)
      IDLE: begin
        if (ENABLE && !SFIFO_EMPTY) begin
          evlen_d  = LEN_W'(ev_len(DRS_READDEPTH));
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        rden_d = ~SFIFO_EMPTY & room & more_to_read;
        if (rd_cnt_q == evlen_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q && !rden_q && (skid_cnt == '0) && (wr_cnt_q == evlen_q)) begin
          event_done_d  = 1'b1;
          event_count_d = event_count_q + 32'd1;
          busy_d        = 1'b0;
          state_d       = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      evlen_q       <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      rden_q        <= 1'b0;
      inflight_q    <= 1'b0;
      tx_wr_q       <= 1'b0;
      tx_data_q     <= '0;
      event_done_q  <= 1'b0;
      event_count_q <= '0;
      busy_q        <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      evlen_q       <= evlen_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      rden_q        <= rden_d;
      inflight_q    <= inflight_d;
      tx_wr_q       <= tx_wr_d;
      tx_data_q     <= tx_data_d;
      event_done_q  <= event_done_d;
      event_count_q <= event_count_d;
      busy_q        <= busy_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign SFIFO_RDCLK = CLK;
  assign SFIFO_RDEN  = rden_q;
  assign TCP_TX_WR   = tx_wr_q;
  assign TCP_TX_DATA = tx_data_q;
  assign EVENT_DONE  = event_done_q;
  assign EVENT_COUNT = event_count_q;
  assign BUSY        = busy_q;
  assign PROTO_ERR   = proto_err_q;

endmodule

// File: tb/tb_event_stream_reader.sv
// Directed bench: table of whole-event scenarios plus hand sequences for enable drop,
// mid-event reset and stray VALID. A FIFO model feeds bytes; the sink checks order and backpressure.
`timescale 1ns/1ps
module tb_event_stream_reader;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ENABLE = 1'b0;
  logic [12:0] DRS_READDEPTH = '0;
  logic        SFIFO_RDCLK;
  logic        SFIFO_RDEN;
  logic [7:0]  SFIFO_DOUT = '0;
  logic        SFIFO_EMPTY = 1'b1;
  logic        SFIFO_VALID = 1'b0;
  logic        TCP_TX_FULL = 1'b0;
  logic        TCP_TX_WR;
  logic [7:0]  TCP_TX_DATA;
  logic        EVENT_DONE;
  logic [31:0] EVENT_COUNT;
  logic        BUSY;
  logic        PROTO_ERR;

  always #5 CLK = ~CLK;

  event_stream_reader #(.SKID_DEPTH(4), .LEN_W(20)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .ENABLE        (ENABLE),
    .DRS_READDEPTH (DRS_READDEPTH),
    .SFIFO_RDCLK   (SFIFO_RDCLK),
    .SFIFO_RDEN    (SFIFO_RDEN),
    .SFIFO_DOUT    (SFIFO_DOUT),
    .SFIFO_EMPTY   (SFIFO_EMPTY),
    .SFIFO_VALID   (SFIFO_VALID),
    .TCP_TX_FULL   (TCP_TX_FULL),
    .TCP_TX_WR     (TCP_TX_WR),
    .TCP_TX_DATA   (TCP_TX_DATA),
    .EVENT_DONE    (EVENT_DONE),
    .EVENT_COUNT   (EVENT_COUNT),
    .BUSY          (BUSY),
    .PROTO_ERR     (PROTO_ERR)
  );

  typedef struct {
    string       name;
    logic [12:0] depth;
    int          events;
    int          full_hi;
    int          full_lo;
    int          gap_pct;
    int          exp_bytes;
    int          exp_done;
  } vec_t;

  int applied = 0;
  int miscompares = 0;

  byte unsigned fifo_q[$];
  byte unsigned exp_q[$];
  int   wr_total, rd_fires, rden_raw, done_cnt, bad_data, full_viol, max_skid;
  int   wr_at_first_done, exp_evcount, phase;
  int   full_hi = 0, full_lo = 0, gap_pct = 0;
  logic full_prev = 1'b0;
  logic inject = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    wr_total = 0; rd_fires = 0; rden_raw = 0; done_cnt = 0; bad_data = 0;
    full_viol = 0; max_skid = 0; wr_at_first_done = -1; phase = 0; full_prev = 1'b0;
  endtask

  function automatic byte unsigned pat(input int idx);
    return 8'(idx ^ (idx >> 8));
  endfunction

  // Observe one cycle at the negedge, then drive the next cycle's inputs just after posedge.
  task automatic cycle();
    logic fire;
    byte unsigned rb;
    @(negedge CLK);
    fire = SFIFO_RDEN && !SFIFO_EMPTY && (fifo_q.size() > 0);
    rb = 8'h00;
    if (SFIFO_RDEN) rden_raw++;
    if (fire) begin
      rb = fifo_q.pop_front();
      rd_fires++;
    end
    if (TCP_TX_WR) begin
      if (full_prev) full_viol++;
      if (exp_q.size() == 0) bad_data++;
      else if (TCP_TX_DATA != exp_q.pop_front()) bad_data++;
      wr_total++;
    end
    if (EVENT_DONE) begin
      done_cnt++;
      if (done_cnt == 1) wr_at_first_done = wr_total;
    end
    if (int'(dut.skid_cnt) > max_skid) max_skid = int'(dut.skid_cnt);
    full_prev = TCP_TX_FULL;
    @(posedge CLK);
    #1;
    SFIFO_VALID = fire || inject;
    SFIFO_DOUT  = inject ? 8'hAA : rb;
    phase++;
    TCP_TX_FULL = (full_hi > 0) && ((phase % (full_hi + full_lo)) < full_hi);
    SFIFO_EMPTY = (fifo_q.size() == 0) || ((gap_pct > 0) && ($urandom_range(0, 99) < gap_pct));
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(pat(i));
      exp_q.push_back(pat(i));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int len, budget, n;
    clear_stats();
    full_hi = v.full_hi; full_lo = v.full_lo; gap_pct = v.gap_pct;
    DRS_READDEPTH = v.depth;
    ENABLE = 1'b1;
    len = v.exp_bytes / v.events;
    preload(v.exp_bytes);
    budget = v.exp_bytes * 3 + 100;
    n = 0;
    while (done_cnt < v.exp_done && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check({v.name, " timeout"}, done_cnt, v.exp_done);
    full_hi = 0; gap_pct = 0;
    for (int i = 0; i < 20; i++) cycle();
    exp_evcount += v.events;
    check({v.name, " bytes written"}, wr_total, v.exp_bytes);
    check({v.name, " data errors"}, bad_data, 0);
    check({v.name, " done pulses"}, done_cnt, v.exp_done);
    check({v.name, " writes at first done"}, wr_at_first_done, len);
    check({v.name, " event count"}, EVENT_COUNT, exp_evcount);
    check({v.name, " fifo reads"}, rd_fires, v.exp_bytes);
    if (v.gap_pct == 0) check({v.name, " rden strobes"}, rden_raw, v.exp_bytes);
    check({v.name, " write while full"}, full_viol, 0);
    check({v.name, " skid over depth"}, int'(max_skid > 4), 0);
    check({v.name, " busy after"}, BUSY, 0);
    $display("vec %s: depth=%0d bytes=%0d done=%0d count=%0d max_skid=%0d",
             v.name, v.depth, wr_total, done_cnt, EVENT_COUNT, max_skid);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " TX_WR"}, TCP_TX_WR, 0);
    check({tag, " TX_DATA"}, TCP_TX_DATA, 0);
    check({tag, " RDEN"}, SFIFO_RDEN, 0);
    check({tag, " BUSY"}, BUSY, 0);
    check({tag, " EVENT_DONE"}, EVENT_DONE, 0);
    check({tag, " EVENT_COUNT"}, EVENT_COUNT, 0);
    check({tag, " PROTO_ERR"}, PROTO_ERR, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int n;
    tbl[0] = '{"d1_96",       13'd1,    1, 0, 0, 0,  96,    1};
    tbl[1] = '{"d0_64",       13'd0,    1, 0, 0, 0,  64,    1};
    tbl[2] = '{"d4_gaps_x2",  13'd4,    2, 0, 0, 30, 384,   2};
    tbl[3] = '{"d1024_full",  13'd1024, 1, 3, 5, 0,  32832, 1};
    tbl[4] = '{"d2_full_gap", 13'd2,    1, 1, 1, 20, 128,   1};

    RST_N = 1'b0;
    exp_evcount = 0;
    clear_stats();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    for (int k = 0; k < 5; k++) run_vec(tbl[k]);

    // ENABLE dropped and depth changed after 10 bytes: event finishes at the latched depth.
    clear_stats();
    DRS_READDEPTH = 13'd2;
    ENABLE = 1'b1;
    preload(128);
    for (int i = 0; i < 64; i++) fifo_q.push_back(8'h5A);
    n = 0;
    while (wr_total < 10 && n < 200) begin cycle(); n++; end
    ENABLE = 1'b0;
    DRS_READDEPTH = 13'd9;
    n = 0;
    while (done_cnt < 1 && n < 600) begin cycle(); n++; end
    for (int i = 0; i < 40; i++) cycle();
    exp_evcount += 1;
    check("enable drop bytes", wr_total, 128);
    check("enable drop data errors", bad_data, 0);
    check("enable drop done pulses", done_cnt, 1);
    check("enable drop left in fifo", fifo_q.size(), 64);
    check("enable drop busy", BUSY, 0);
    check("enable drop event count", EVENT_COUNT, exp_evcount);
    $display("seq enable_drop: bytes=%0d left=%0d", wr_total, fifo_q.size());
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) cycle();

    // Reset after 50 bytes of a 96-byte event, then a clean event.
    clear_stats();
    DRS_READDEPTH = 13'd1;
    ENABLE = 1'b1;
    preload(96);
    n = 0;
    while (wr_total < 50 && n < 400) begin cycle(); n++; end
    check("pre-reset busy", BUSY, 1);
    RST_N = 1'b0;
    SFIFO_VALID = 1'b0;
    #2;
    check_reset_outputs("mid reset");
    fifo_q.delete();
    exp_q.delete();
    exp_evcount = 0;
    for (int i = 0; i < 3; i++) cycle();
    RST_N = 1'b1;
    for (int i = 0; i < 2; i++) cycle();
    $display("seq mid_reset: bytes before reset=%0d", wr_total);
    run_vec(tbl[0]);

    // Stray VALID while idle: flagged, not forwarded, sticky until reset.
    clear_stats();
    ENABLE = 1'b0;
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("stray valid proto_err", PROTO_ERR, 1);
    check("stray valid forwarded", wr_total, 0);
    for (int i = 0; i < 20; i++) cycle();
    check("proto_err sticky", PROTO_ERR, 1);
    run_vec(tbl[1]);
    check("proto_err sticky after event", PROTO_ERR, 1);
    RST_N = 1'b0;
    #2;
    check("proto_err cleared by reset", PROTO_ERR, 0);
    $display("seq stray_valid: proto_err cleared by reset");
    RST_N = 1'b1;
    for (int i = 0; i < 2; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
